ysyx_24100005_mem_arbiter: RTL and testbench

Two-master, one-slave arbiter sharing the core's single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) in the multi-cycle NPC. It accepts one request at a time, latches it, and drives it to memory over a valid/ready handshake. It routes the response back to the owning master. Arbitration is fixed-priority in favour of the LSU, with a starvation guard that forces an IFU grant.

---
 rtl/ysyx_24100005_mem_pkg.sv | 15 +
 rtl/ysyx_24100005_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
package ysyx_24100005_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

endpackage

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares the single memory port between IFU and LSU: fixed LSU priority with a
// starvation guard, one outstanding transaction, response routed to the owner.
module ysyx_24100005_mem_arbiter
   import ysyx_24100005_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,

   output logic                busy,
   output logic                err
);

   localparam int MASK_W   = DATA_W / 8;
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   state_e              state_q,  state_d;
   owner_e              owner_q,  owner_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic                wen_q,    wen_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [MASK_W-1:0]   wmask_q,  wmask_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                err_q,    err_d;

   logic grant_lsu;
   logic grant_ifu;
   logic owner_rsp_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IFU;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   assign mem_addr        = addr_q;
   assign mem_wen         = wen_q;
   assign mem_wdata       = wdata_q;
   assign mem_wmask       = wmask_q;
   assign busy            = (state_q != IDLE);
   assign err             = err_q;
   assign owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      addr_d        = addr_q;
      wen_d         = wen_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      starve_d      = starve_q;
      err_d         = err_q;
      grant_lsu     = 1'b0;
      grant_ifu     = 1'b0;
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      ifu_rdata     = '0;
      lsu_rdata     = '0;

      case (state_q)
         IDLE: begin
            // LSU wins unless the IFU has been passed over STARVE_MAX times in a row.
            grant_lsu     = lsu_req_valid && !(ifu_req_valid && (starve_q == STARVE_LIM));
            grant_ifu     = ifu_req_valid && !grant_lsu;
            lsu_req_ready = grant_lsu;
            ifu_req_ready = grant_ifu;
            if (mem_rsp_valid) begin
               err_d = 1'b1;
            end
            if (grant_lsu) begin
               owner_d = OWN_LSU;
               addr_d  = lsu_addr;
               wen_d   = lsu_wen;
               wdata_d = lsu_wdata;
               wmask_d = lsu_wmask;
               state_d = REQ;
               if (ifu_req_valid && (starve_q != STARVE_LIM)) begin
                  starve_d = starve_q + STARVE_W'(1);
               end
            end else if (grant_ifu) begin
               owner_d  = OWN_IFU;
               addr_d   = ifu_addr;
               wen_d    = 1'b0;
               wdata_d  = '0;
               wmask_d  = '0;
               starve_d = '0;
               state_d  = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_rsp_valid) begin
               err_d = 1'b1;
            end
            if (mem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            mem_rsp_ready = owner_rsp_ready;
            if (owner_q == OWN_LSU) begin
               lsu_rsp_valid = mem_rsp_valid;
               lsu_rdata     = mem_rdata;
            end else begin
               ifu_rsp_valid = mem_rsp_valid;
               ifu_rdata     = mem_rdata;
            end
            if (mem_rsp_valid && owner_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: a cycle model predicts grants,
// memory-side fields and response routing; a simple memory answers requests.
module tb_ysyx_24100005_mem_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready = 1'b1;
   logic [31:0] ifu_addr = '0, ifu_rdata;
   logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready = 1'b1;
   logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
   logic        lsu_wen = 1'b0;
   logic [3:0]  lsu_wmask = '0;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        busy, err;

   always #5 clk = ~clk;

   ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
      .busy(busy), .err(err)
   );

   typedef struct packed {
      logic        own;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } txn_t;

   txn_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_5A5A);
   endfunction

   // ---------------- model / monitor (samples on the falling edge) ----------------
   int          m_state = 0;
   int          m_starve = 0;
   logic        m_err = 1'b0;
   int          cyc = 0;
   bit          grant_log[$];
   int          lsu_rsp_cnt = 0, req_cycles = 0;
   int          last_grant_cyc = 0, last_rsp_cyc = 0;
   logic [31:0] last_ifu_rdata = '0;
   bit          req_hs_flag = 1'b0, rsp_hs_flag = 1'b0;
   logic [31:0] mon_addr = '0;
   txn_t        t;
   logic        exp_l, exp_i, own_rdy;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         m_state = 0; m_starve = 0; m_err = 1'b0;
         exp_q.delete(); req_hs_flag = 1'b0; rsp_hs_flag = 1'b0;
         chk("rst_err", err, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_mem_req_valid", mem_req_valid, 1'b0);
         chk("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
         chk("rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
         chk("rst_req_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
      end else begin
         chk("err", err, m_err);
         case (m_state)
            0: begin
               exp_l = lsu_req_valid && !(ifu_req_valid && (m_starve == SMAX));
               exp_i = ifu_req_valid && !exp_l;
               chk("lsu_req_ready", lsu_req_ready, exp_l);
               chk("ifu_req_ready", ifu_req_ready, exp_i);
               chk("idle_busy", busy, 1'b0);
               chk("idle_mem_req_valid", mem_req_valid, 1'b0);
               chk("idle_mem_rsp_ready", mem_rsp_ready, 1'b0);
               chk("idle_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
               if (mem_rsp_valid) m_err = 1'b1;
               if (exp_l) begin
                  t = '{own: 1'b1, addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
                  exp_q.push_back(t);
                  if (ifu_req_valid && m_starve < SMAX) m_starve++;
                  grant_log.push_back(1'b1);
                  last_grant_cyc = cyc;
                  m_state = 1;
               end else if (exp_i) begin
                  t = '{own: 1'b0, addr: ifu_addr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0};
                  exp_q.push_back(t);
                  m_starve = 0;
                  grant_log.push_back(1'b0);
                  last_grant_cyc = cyc;
                  m_state = 1;
               end
            end
            1: begin
               req_cycles++;
               chk("req_mem_req_valid", mem_req_valid, 1'b1);
               chk("req_busy", busy, 1'b1);
               chk("req_req_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
               chk("req_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
               chk("req_mem_rsp_ready", mem_rsp_ready, 1'b0);
               if (exp_q.size() == 0) begin
                  chk("req_queue_empty", 1'b0, 1'b1);
               end else begin
                  t = exp_q[0];
                  chk("mem_addr", mem_addr, t.addr);
                  chk("mem_wen", mem_wen, t.wen);
                  chk("mem_wdata", mem_wdata, t.wdata);
                  chk("mem_wmask", mem_wmask, t.wmask);
               end
               if (mem_rsp_valid) m_err = 1'b1;
               if (mem_req_ready) begin
                  req_hs_flag = 1'b1;
                  mon_addr = mem_addr;
                  m_state = 2;
               end
            end
            default: begin
               t = (exp_q.size() != 0) ? exp_q[0] : '0;
               own_rdy = t.own ? lsu_rsp_ready : ifu_rsp_ready;
               chk("wait_busy", busy, 1'b1);
               chk("wait_mem_req_valid", mem_req_valid, 1'b0);
               chk("wait_req_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
               chk("mem_rsp_ready", mem_rsp_ready, own_rdy);
               if (t.own) begin
                  chk("lsu_rsp_valid", lsu_rsp_valid, mem_rsp_valid);
                  chk("lsu_rdata", lsu_rdata, mem_rdata);
                  chk("ifu_rsp_valid_nonowner", ifu_rsp_valid, 1'b0);
                  chk("ifu_rdata_nonowner", ifu_rdata, 32'h0);
               end else begin
                  chk("ifu_rsp_valid", ifu_rsp_valid, mem_rsp_valid);
                  chk("ifu_rdata", ifu_rdata, mem_rdata);
                  chk("lsu_rsp_valid_nonowner", lsu_rsp_valid, 1'b0);
                  chk("lsu_rdata_nonowner", lsu_rdata, 32'h0);
               end
               if (mem_rsp_valid && own_rdy) begin
                  chk("rsp_rdata", t.own ? lsu_rdata : ifu_rdata, mem_data(t.addr));
                  if (t.own) lsu_rsp_cnt++;
                  else last_ifu_rdata = ifu_rdata;
                  last_rsp_cyc = cyc;
                  rsp_hs_flag = 1'b1;
                  void'(exp_q.pop_front());
                  m_state = 0;
               end
            end
         endcase
      end
   end

   // ---------------- memory responder (drives 1 time unit after the rising edge) ----------------
   int   req_stall = 0;
   bit   stray = 1'b0;
   bit   have_rsp = 1'b0;

   initial begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata     = '0;
            have_rsp      = 1'b0;
         end else begin
            if (rsp_hs_flag) begin rsp_hs_flag = 1'b0; have_rsp = 1'b0; end
            if (req_hs_flag) begin
               req_hs_flag = 1'b0;
               have_rsp    = 1'b1;
               mem_rdata   = mem_data(mon_addr);
            end
            mem_rsp_valid = have_rsp || stray;
            if (mem_req_valid && req_stall > 0) begin
               mem_req_ready = 1'b0;
               req_stall--;
            end else begin
               mem_req_ready = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus (all changes 2 time units after the rising edge) ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic ifu_req(input logic [31:0] a);
      bit done = 1'b0;
      ifu_req_valid = 1'b1;
      ifu_addr      = a;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (ifu_req_ready) done = 1'b1;
      end
      if (!done) chk("ifu_grant_timeout", 1'b0, 1'b1);
      tick();
      ifu_req_valid = 1'b0;
   endtask

   task automatic lsu_req(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] wm);
      bit done = 1'b0;
      lsu_req_valid = 1'b1;
      lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (lsu_req_ready) done = 1'b1;
      end
      if (!done) chk("lsu_grant_timeout", 1'b0, 1'b1);
      tick();
      lsu_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) done = 1'b1;
      end
      if (!done) chk("idle_timeout", 1'b0, 1'b1);
      tick();
   endtask

   task automatic wait_lsu_rsp();
      bit done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (lsu_rsp_valid) done = 1'b1;
      end
      if (!done) chk("lsu_rsp_timeout", 1'b0, 1'b1);
   endtask

   logic [9:0] starve_pat;
   int         cnt0, req0;

   initial begin
      repeat (3) tick();
      chk("reset_busy", busy, 1'b0);
      chk("reset_err", err, 1'b0);
      rst = 1'b1;
      repeat (2) tick();

      // IFU alone, zero-wait memory
      ifu_req(32'h8000_0000);
      wait_idle();
      chk("ifu_rsp_latency", last_rsp_cyc - last_grant_cyc, 2);
      chk("ifu_rdata_first", last_ifu_rdata, 32'h0000_0413);
      $display("txn ifu_only addr=80000000 rdata=%08h", last_ifu_rdata);

      // both request together: LSU write first, then IFU
      grant_log.delete();
      fork
         ifu_req(32'h8000_0004);
         lsu_req(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
      join
      wait_idle();
      chk("simul_grants", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         chk("simul_first_lsu", grant_log[0], 1'b1);
         chk("simul_second_ifu", grant_log[1], 1'b0);
      end
      $display("txn simultaneous grants=%0d", grant_log.size());

      // starvation guard: continuous requests from both masters
      grant_log.delete();
      starve_pat = 10'b0111101111;
      fork
         for (int i = 0; i < 8; i++)
            lsu_req(32'h8000_3000 + 32'(i * 4), 1'(i % 2), 32'h0101_0101 * 32'(i + 1), 4'b0011);
         for (int i = 0; i < 2; i++)
            ifu_req(32'h8000_0100 + 32'(i * 4));
      join
      wait_idle();
      chk("starve_grants", grant_log.size(), 10);
      for (int i = 0; i < 10 && i < grant_log.size(); i++)
         chk("starve_seq", grant_log[i], starve_pat[i]);
      $display("txn starvation grants=%0d", grant_log.size());

      // backpressure: memory request stall then LSU response stall
      cnt0 = lsu_rsp_cnt;
      req0 = req_cycles;
      req_stall = 5;
      lsu_rsp_ready = 1'b0;
      lsu_req(32'h8000_2000, 1'b0, 32'h0, 4'h0);
      wait_lsu_rsp();
      repeat (2) @(negedge clk);
      tick();
      lsu_rsp_ready = 1'b1;
      wait_idle();
      chk("bp_single_rsp", lsu_rsp_cnt - cnt0, 1);
      chk("bp_req_cycles", req_cycles - req0, 6);
      $display("txn backpressure rsp=%0d req_cycles=%0d", lsu_rsp_cnt - cnt0, req_cycles - req0);

      // stray response sets sticky err; reset in WAIT clears everything
      stray = 1'b1;
      tick();
      stray = 1'b0;
      repeat (3) tick();
      chk("err_sticky", err, 1'b1);
      lsu_rsp_ready = 1'b0;
      lsu_req(32'h8000_4000, 1'b0, 32'h0, 4'h0);
      wait_lsu_rsp();
      tick();
      rst = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_err", err, 1'b0);
      chk("arst_mem_req_valid", mem_req_valid, 1'b0);
      chk("arst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
      chk("arst_mem_rsp_ready", mem_rsp_ready, 1'b0);
      $display("txn reset_in_wait busy=%0b err=%0b", busy, err);
      lsu_rsp_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      ifu_req(32'h8000_0008);
      wait_idle();
      chk("err_after_reset", err, 1'b0);
      $display("txn post_reset ifu rdata=%08h", last_ifu_rdata);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
